// File: rtl/mem_seq_pkg.sv
// Shared encodings for the multi-byte memory transfer sequencer:
// request size codes, FSM state enum, wait-state limits and byte-count helper.
package mem_seq_pkg;

  // Largest supported number of extra wait cycles per byte access.
  localparam int MEM_WAIT_MAX = 7;
  // Wait counter width, wide enough for 0..MEM_WAIT_MAX.
  localparam int WAIT_CNT_W   = 3;

  // Request size encodings carried on the Size input.
  typedef enum logic [1:0] {
    SIZE_1B      = 2'b00,
    SIZE_2B      = 2'b01,
    SIZE_4B      = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Number of bytes moved for a size code (0 for the illegal code).
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_1B: n = 3'd1;
      SIZE_2B: n = 3'd2;
      SIZE_4B: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_transfer_sequencer_byte_slot_timer.sv
// Per-byte slot timer: counts 0..MEM_WAIT inside one byte access slot and
// flags the final cycle of the slot. Wraps to zero after the last cycle so
// consecutive slots run back to back.
module byte_slot_timer
  import mem_seq_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic slot_last
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  assign slot_last = (cnt_q == WAIT_CNT_W'(MEM_WAIT));

  // Next count: clear outside a slot, wrap at the slot end, else advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {WAIT_CNT_W{1'b0}};
    end else if (en) begin
      if (slot_last) begin
        cnt_d = {WAIT_CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {WAIT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_transfer_sequencer.sv
// Multi-byte memory transfer sequencer. Accepts one load/store request of
// 1, 2 or 4 bytes, addressed through AR (ascending) or SP (stack), and drives
// the memory chip select / write, pointer step, DR clear / shift-in and
// store-byte select strobes. All outputs decode registered state only, so
// Start never reaches the memory strobes combinationally.
module mem_transfer_sequencer
  import mem_seq_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Write,
  input  logic [1:0] Size,
  input  logic       UseSP,
  output logic       Ready,
  output logic       Done,
  output logic       Err,
  output logic       Mem_CS,
  output logic       Mem_WR,
  output logic       PtrSel,
  output logic       PtrInc,
  output logic       PtrDec,
  output logic       DR_Clear,
  output logic       DR_Load,
  output logic [1:0] ByteSel
);

  state_e     state_q,    state_d;
  logic [1:0] k_q,        k_d;
  logic [1:0] last_idx_q, last_idx_d;
  logic       write_q,    write_d;
  logic       use_sp_q,   use_sp_d;
  logic       err_q,      err_d;

  logic       slot_last_s;
  logic       in_access_s;
  logic       push_s;

  assign in_access_s = (state_q == ST_ACCESS);
  // Push is the only mode that walks bytes LSB first and steps the pointer down.
  assign push_s      = use_sp_q & write_q;

  byte_slot_timer #(
    .MEM_WAIT (MEM_WAIT)
  ) u_slot_timer (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (~in_access_s),
    .en        (in_access_s),
    .slot_last (slot_last_s)
  );

  // Next-state logic: request capture in IDLE, byte stepping in ACCESS.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    last_idx_d = last_idx_q;
    write_d    = write_q;
    use_sp_d   = use_sp_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Size == SIZE_ILLEGAL) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            write_d    = Write;
            use_sp_d   = UseSP;
            last_idx_d = 2'(byte_count(Size) - 3'd1);
            k_d        = 2'd0;
            state_d    = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (slot_last_s) begin
          if (k_q == last_idx_q) begin
            k_d     = 2'd0;
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        k_d     = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, byte index, latched request and error pulse registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      k_q        <= 2'd0;
      last_idx_q <= 2'd0;
      write_q    <= 1'b0;
      use_sp_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      last_idx_q <= last_idx_d;
      write_q    <= write_d;
      use_sp_q   <= use_sp_d;
      err_q      <= err_d;
    end
  end

  // Output decode from registered state; strobes that move data or pointers
  // fire only in the last cycle of each byte slot.
  always_comb begin
    Ready    = (state_q == ST_IDLE);
    Done     = (state_q == ST_DONE);
    Err      = err_q;
    Mem_CS   = ~in_access_s;
    Mem_WR   = in_access_s & write_q;
    PtrSel   = (state_q != ST_IDLE) & use_sp_q;
    PtrInc   = 1'b0;
    PtrDec   = 1'b0;
    DR_Clear = 1'b0;
    DR_Load  = 1'b0;
    ByteSel  = 2'd0;
    case (state_q)
      ST_SETUP: begin
        // Loads start from a zeroed DR; a pop pre-increments SP.
        DR_Clear = ~write_q;
        PtrInc   = use_sp_q & ~write_q;
      end
      ST_ACCESS: begin
        if (push_s) begin
          ByteSel = k_q;
        end else begin
          ByteSel = last_idx_q - k_q;
        end
        if (slot_last_s) begin
          DR_Load = ~write_q;
          if (push_s) begin
            PtrDec = 1'b1;
          end else begin
            PtrInc = (k_q != last_idx_q);
          end
        end else begin
          DR_Load = 1'b0;
        end
      end
      ST_IDLE, ST_DONE: begin
        ByteSel = 2'd0;
      end
      default: begin
        ByteSel = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_transfer_sequencer.sv
// Self-checking bench for mem_transfer_sequencer. A small behavioural model
// of AR, SP, DR and a 256-byte memory reacts to the DUT strobes; a table of
// transfers checks per-cycle strobe masks and final pointer/DR/memory state,
// and hand-written sequences cover illegal size, reset abort and wait states.
module tb_mem_transfer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (MEM_WAIT = 0)
  logic       rst = 1'b1;
  logic       start = 1'b0, write = 1'b0, use_sp = 1'b0;
  logic [1:0] size = 2'd0;
  logic       ready, done, err, mem_cs, mem_wr, ptr_sel, ptr_inc, ptr_dec, dr_clear, dr_load;
  logic [1:0] bsel;

  // Second DUT (MEM_WAIT = 2)
  logic       start2 = 1'b0, write2 = 1'b0, use_sp2 = 1'b0;
  logic [1:0] size2 = 2'd0;
  logic       ready2, done2, err2, cs2, wr2, psel2, inc2, dec2, clr2, dl2;
  logic [1:0] bsel2;

  mem_transfer_sequencer #(.MEM_WAIT(0)) u_dut (
    .Clock(clk), .Reset(rst), .Start(start), .Write(write), .Size(size), .UseSP(use_sp),
    .Ready(ready), .Done(done), .Err(err), .Mem_CS(mem_cs), .Mem_WR(mem_wr),
    .PtrSel(ptr_sel), .PtrInc(ptr_inc), .PtrDec(ptr_dec), .DR_Clear(dr_clear),
    .DR_Load(dr_load), .ByteSel(bsel)
  );

  mem_transfer_sequencer #(.MEM_WAIT(2)) u_dut_w2 (
    .Clock(clk), .Reset(rst), .Start(start2), .Write(write2), .Size(size2), .UseSP(use_sp2),
    .Ready(ready2), .Done(done2), .Err(err2), .Mem_CS(cs2), .Mem_WR(wr2),
    .PtrSel(psel2), .PtrInc(inc2), .PtrDec(dec2), .DR_Clear(clr2),
    .DR_Load(dl2), .ByteSel(bsel2)
  );

  // Environment model: pointers, DR and memory driven by the main DUT strobes.
  logic [15:0] ar, sp, env_ar = 16'h0, env_sp = 16'h0;
  logic [31:0] dr, src_word = 32'h0;
  logic [7:0]  mem [0:255];
  logic        env_load = 1'b0, mem_clr = 1'b0;
  logic [7:0]  addr;
  assign addr = ptr_sel ? sp[7:0] : ar[7:0];

  // Model of the ALU-side registers and byte-wide memory.
  always @(posedge clk) begin
    if (env_load) begin
      ar <= env_ar;
      sp <= env_sp;
    end else begin
      if (ptr_inc) begin
        if (ptr_sel) sp <= sp + 16'd1; else ar <= ar + 16'd1;
      end
      if (ptr_dec) begin
        if (ptr_sel) sp <= sp - 16'd1; else ar <= ar - 16'd1;
      end
    end
    if (dr_clear) dr <= 32'h0;
    else if (dr_load) dr <= {dr[23:0], mem[addr]};
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (!mem_cs && mem_wr) begin
      mem[addr] <= src_word[{bsel, 3'b000} +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs_main();
    return {ready, done, err, mem_cs, mem_wr, ptr_sel, ptr_inc, ptr_dec, dr_clear, dr_load, bsel};
  endfunction

  function automatic logic [11:0] outs_w2();
    return {ready2, done2, err2, cs2, wr2, psel2, inc2, dec2, clr2, dl2, bsel2};
  endfunction

  // Per-cycle logs of one transfer (bit c = cycle c after the accepting edge)
  logic [15:0] inc_m, dec_m, cs_m, wr_m, done_m, ready_m;
  logic [31:0] bsel_m;

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic spm, input logic [31:0] word);
    inc_m = '0; dec_m = '0; cs_m = '0; wr_m = '0; done_m = '0; ready_m = '0; bsel_m = '0;
    write = w; size = sz; use_sp = spm; src_word = word; start = 1'b1;
    for (int c = 1; c < 16; c++) begin
      step();
      start = 1'b0;
      if (ptr_inc) inc_m[c] = 1'b1;
      if (ptr_dec) dec_m[c] = 1'b1;
      if (!mem_cs) begin
        cs_m[c] = 1'b1;
        bsel_m[2*c +: 2] = bsel;
      end
      if (mem_wr) wr_m[c] = 1'b1;
      if (done) done_m[c] = 1'b1;
      if (ready) ready_m[c] = 1'b1;
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        spm;
    logic [31:0] word;
    logic [15:0] ar0, sp0;
    int          done_c;
    logic [15:0] inc, dec, cs;
    logic [31:0] bsel;
    logic [15:0] ar1, sp1;
    logic [31:0] dr;
  } vec_t;

  vec_t vecs [8];

  logic [15:0] cs2_m, dl2_m, done2_m, ready2_m, err2_m;
  int          n_done;

  initial begin
    //            w     sz     sp    word          ar0       sp0    done  inc       dec       cs        bsel          ar1       sp1       dr
    vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h06000A08, 16'h0008, 16'h00FF, 6, 16'h001C, 16'h0000, 16'h003C, 32'h000001B0, 16'h000B, 16'h00FF, 32'h0};
    vecs[1] = '{1'b1, 2'd1, 1'b1, 32'h0000AABB, 16'h000B, 16'h00FF, 4, 16'h0000, 16'h000C, 16'h000C, 32'h00000040, 16'h000B, 16'h00FD, 32'h0};
    vecs[2] = '{1'b0, 2'd1, 1'b1, 32'h0,        16'h000B, 16'h00FD, 4, 16'h0006, 16'h0000, 16'h000C, 32'h0,        16'h000B, 16'h00FF, 32'h0000AABB};
    vecs[3] = '{1'b0, 2'd2, 1'b0, 32'h0,        16'h0008, 16'h00FF, 6, 16'h001C, 16'h0000, 16'h003C, 32'h0,        16'h000B, 16'h00FF, 32'h06000A08};
    vecs[4] = '{1'b0, 2'd0, 1'b0, 32'h0,        16'h00FE, 16'h00FF, 3, 16'h0000, 16'h0000, 16'h0004, 32'h0,        16'h00FE, 16'h00FF, 32'h000000AA};
    vecs[5] = '{1'b1, 2'd2, 1'b1, 32'h11223344, 16'h0000, 16'h0080, 6, 16'h0000, 16'h003C, 16'h003C, 32'h00000E40, 16'h0000, 16'h007C, 32'h0};
    vecs[6] = '{1'b0, 2'd2, 1'b1, 32'h0,        16'h0000, 16'h007C, 6, 16'h001E, 16'h0000, 16'h003C, 32'h0,        16'h0000, 16'h0080, 32'h11223344};
    vecs[7] = '{1'b1, 2'd0, 1'b0, 32'h000000C3, 16'h0020, 16'h0080, 3, 16'h0000, 16'h0000, 16'h0004, 32'h0,        16'h0020, 16'h0080, 32'h0};

    // Reset with memory clear
    env_load = 1'b1; mem_clr = 1'b1;
    step(); step();
    rst = 1'b0; env_load = 1'b0; mem_clr = 1'b0;
    check("reset_outs", 32'(outs_main()), 32'h900);
    check("reset_outs_w2", 32'(outs_w2()), 32'h900);

    // Table-driven transfers
    for (int i = 0; i < 8; i++) begin
      env_load = 1'b1; env_ar = vecs[i].ar0; env_sp = vecs[i].sp0;
      step();
      env_load = 1'b0;
      run_txn(vecs[i].w, vecs[i].sz, vecs[i].spm, vecs[i].word);
      check($sformatf("v%0d_done", i), 32'(done_m), 32'h1 << vecs[i].done_c);
      check($sformatf("v%0d_ready", i), 32'(ready_m), (32'h0000FFFF << (vecs[i].done_c + 1)) & 32'h0000FFFF);
      check($sformatf("v%0d_inc", i), 32'(inc_m), 32'(vecs[i].inc));
      check($sformatf("v%0d_dec", i), 32'(dec_m), 32'(vecs[i].dec));
      check($sformatf("v%0d_cs", i), 32'(cs_m), 32'(vecs[i].cs));
      check($sformatf("v%0d_wr", i), 32'(wr_m), vecs[i].w ? 32'(vecs[i].cs) : 32'h0);
      if (vecs[i].w) check($sformatf("v%0d_bsel", i), bsel_m, vecs[i].bsel);
      else check($sformatf("v%0d_dr", i), dr, vecs[i].dr);
      check($sformatf("v%0d_ar", i), 32'(ar), 32'(vecs[i].ar1));
      check($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].sp1));
    end

    // Memory contents left by the stores
    check("mem_ar_store", {mem[8'h08], mem[8'h09], mem[8'h0A], mem[8'h0B]}, 32'h06000A08);
    check("mem_push2", {16'h0, mem[8'hFE], mem[8'hFF]}, 32'h0000AABB);
    check("mem_push4", {mem[8'h7D], mem[8'h7E], mem[8'h7F], mem[8'h80]}, 32'h11223344);
    check("mem_store1", {24'h0, mem[8'h20]}, 32'h000000C3);

    // Illegal size: one-cycle Err, stays ready, no strobes
    write = 1'b1; size = 2'b11; use_sp = 1'b0; start = 1'b1;
    step();
    start = 1'b0; size = 2'b00;
    check("illegal_err_cycle", 32'(outs_main()), 32'hB00);
    step();
    check("illegal_after", 32'(outs_main()), 32'h900);

    // Reset during the second slot of a 4-byte AR store
    env_load = 1'b1; env_ar = 16'h0040; env_sp = 16'h00FF; mem_clr = 1'b1;
    step();
    env_load = 1'b0; mem_clr = 1'b0;
    write = 1'b1; size = 2'd2; use_sp = 1'b0; src_word = 32'hA1B2C3D4; start = 1'b1;
    step();                 // cycle 1
    start = 1'b0;
    step();                 // cycle 2
    step();                 // cycle 3
    rst = 1'b1;
    step();                 // cycle 4
    rst = 1'b0;
    check("abort_idle", 32'(outs_main()), 32'h900);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_mem_first", {24'h0, mem[8'h40]}, 32'h000000A1);
    check("abort_mem_untouched", {16'h0, mem[8'h42], mem[8'h43]}, 32'h0);
    check("abort_ar", 32'(ar), 32'h00000042);

    // MEM_WAIT=2 AR load of one byte, stray Start in cycle 3
    cs2_m = '0; dl2_m = '0; done2_m = '0; ready2_m = '0; err2_m = '0;
    write2 = 1'b0; size2 = 2'd0; use_sp2 = 1'b0; start2 = 1'b1;
    for (int c = 1; c < 13; c++) begin
      step();
      start2 = (c == 3);
      if (!cs2) cs2_m[c] = 1'b1;
      if (dl2) dl2_m[c] = 1'b1;
      if (done2) done2_m[c] = 1'b1;
      if (ready2) ready2_m[c] = 1'b1;
      if (err2) err2_m[c] = 1'b1;
    end
    start2 = 1'b0;
    check("w2_cs", 32'(cs2_m), 32'h001C);
    check("w2_drload", 32'(dl2_m), 32'h0010);
    check("w2_done", 32'(done2_m), 32'h0020);
    check("w2_ready", 32'(ready2_m), 32'h1FC0);
    check("w2_err", 32'(err2_m), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_transfer_sequencer.md
# mem_transfer_sequencer

Multi-byte memory transfer controller for the CPU system's byte-wide memory. Given one request (load/store, 1/2/4 bytes, AR- or SP-addressed), it sequences memory chip-select/write, per-byte pointer increment/decrement, DR byte shift-in and store-byte selection. The instruction control unit hands it the memory phase of LD/ST/PUSH/POP/CALL/RET and waits for `Done`. Pointer registers, DR and memory stay in the ALU system; this block only drives their strobes.

## Interface
- `MEM_WAIT`, 0: extra wait cycles per byte access (0–7).
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  request strobe; accepted only when `Ready`=1.
- `Write`  in  1  0 = load into DR, 1 = store from selected source word.
- `Size`  in  2  00 = 1 byte, 01 = 2, 10 = 4, 11 = illegal.
- `UseSP`  in  1  0 = AR addressing (ascending), 1 = SP stack addressing.
- `Ready`  out 1  idle, can accept `Start`.
- `Done`  out 1  one-cycle completion pulse.
- `Err`  out 1  one-cycle pulse on illegal request.
- `Mem_CS`  out 1  memory chip select, active-low.
- `Mem_WR`  out 1  1 = write.
- `PtrSel`  out 1  0 = AR, 1 = SP drives the memory address.
- `PtrInc`, `PtrDec`  out 1 each  increment/decrement the selected pointer at the next edge; never both.
- `DR_Clear`  out 1  DR <= 0.
- `DR_Load`  out 1  DR <= {DR[23:0], mem_byte}.
- `ByteSel`  out 2  byte of source word driven to memory (3 = MSB).

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: `Ready`=1, `Mem_CS`=1, all other strobes 0. Start with legal Size: latch Write/Size/UseSP, N = 1/2/4, byte index k = 0, go SETUP. Start with Size=11: `Err`=1 next cycle, stay IDLE.
- SETUP (1 cycle): loads assert `DR_Clear` (result zero-extended); SP loads (pop) also assert `PtrInc` (pre-increment). `PtrSel` valid from SETUP through DONE.
- ACCESS: one slot of MEM_WAIT+1 cycles per byte, `Mem_CS`=0 for the whole slot, `Mem_WR`=Write for the whole slot. `DR_Load` and pointer strobes only in the last cycle of the slot. After slot N-1, go DONE.
- Pointer and byte order per slot k:
  - AR load/store: MSB first, `ByteSel` = N-1-k; `PtrInc` if k < N-1. AR ends at start+N-1.
  - SP store (push): LSB first, `ByteSel` = k; `PtrDec` every slot. SP ends at start-N.
  - SP load (pop): MSB first; `PtrInc` if k < N-1. With the SETUP increment, SP ends at start+N.
- DONE (1 cycle): `Done`=1, `Mem_CS`=1. Next state IDLE.
- Request inputs are ignored while not IDLE. Start during busy is dropped, not queued.
- Reset in any state: next edge forces IDLE and k = 0, clears the wait counter, deasserts all strobes, sets `Mem_CS`=1. No `Done` for an aborted transfer.
- All outputs are registered-state decodes, with no combinational path from Start to the memory strobes.

## Timing
- Cycle 0 = accepting edge. Cycle 1 = SETUP. Slots occupy cycles 2 .. 1+N(W+1). `Done` is high in cycle 2+N(W+1). `Ready` is high again in the following cycle.
- W=0, N=4: 6 cycles to `Done`; back-to-back requests every 7 cycles.
- Reset values: `Ready`=1, `Mem_CS`=1, every other output 0, `ByteSel`=0.

## Structure
- Package `mem_seq_pkg`: Size encodings, byte-count function, state enum, MEM_WAIT maximum.
- Sub-module `byte_slot_timer`: wait counter (0..MEM_WAIT) with `slot_last` output and synchronous clear.
- Top: FSM, 2-bit byte index, latched request, output decode.

## Test plan
- Reset → `Ready`=1, `Mem_CS`=1, all strobes 0. Assert `Reset` during slot 2 of a 4-byte store → IDLE next edge, no `Done`, memory beyond bytes already written unchanged.
- AR store, N=4, W=0, AR=0x0008, word 0x06000A08 → `ByteSel` 3,2,1,0 in cycles 2–5, `PtrInc` in cycles 2–4 only, mem[08..0B]=06,00,0A,08, AR=0x000B, `Done` in cycle 6.
- SP push, N=2, SP=0x00FF, word 0x0000AABB → mem[FF]=BB, mem[FE]=AA, SP=0x00FD, `PtrDec` in cycles 2 and 3.
- SP pop, N=2, SP=0x00FD, memory from the previous test → `PtrInc` in cycles 1 and 2, DR=0x0000AABB, SP=0x00FF.
- MEM_WAIT=2, AR load, N=1 → `Mem_CS`=0 for cycles 2–4, `DR_Load` only in cycle 4, `Done` in cycle 5. Start pulsed in cycle 3 → ignored.
- Start with Size=11 → `Err` pulse one cycle, `Ready` stays 1, no memory strobes.
